oc8051_muldiv_seq: RTL

Multi-cycle multiply/divide engine that services MUL AB and DIV AB requests issued by the 8051 ALU.
- The ALU is the initiator: it raises start with an operation select and the A/B operands.
- This block is the responder: it iterates one bit per clock, pulses done, and holds the A/B/OV results stable for write-back.
- It replaces free-running enable-style arithmetic with an explicit start/busy/done handshake of fixed latency.

---
 rtl/oc8051_muldiv_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/oc8051_muldiv_seq.sv
// oc8051 sequential MUL AB / DIV AB engine.
// One bit per clock, fixed latency, start/busy/done handshake.
module oc8051_muldiv_seq #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op,
   input  logic              clear,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] des1,
   output logic [DATA_W-1:0] des2,
   output logic              desOv
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     count;
   logic              op_q;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W-1:0] hi, lo;
   logic [DATA_W-1:0] hi_nxt, lo_nxt;
   logic              ov_nxt;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W:0]   div_sh;
   logic [DATA_W:0]   div_dif;
   logic              q_bit;

   // hi/lo hold {acc, multiplier} for MUL and {rem, dividend/quotient} for DIV
   always_comb begin
      mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_sh  = {hi, lo[DATA_W-1]};
      div_dif = div_sh - {1'b0, opnd};
      q_bit   = ~div_dif[DATA_W];
      if (op_q) begin
         hi_nxt = q_bit ? div_dif[DATA_W-1:0] : div_sh[DATA_W-1:0];
         lo_nxt = {lo[DATA_W-2:0], q_bit};
         ov_nxt = (opnd == '0);
      end else begin
         hi_nxt = mul_sum[DATA_W:1];
         lo_nxt = {mul_sum[0], lo[DATA_W-1:1]};
         ov_nxt = |hi_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (count == LAST) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         op_q  <= 1'b0;
         opnd  <= '0;
         hi    <= '0;
         lo    <= '0;
         des1  <= '0;
         des2  <= '0;
         desOv <= 1'b0;
      end else begin
         state <= state_nxt;
         if (!clear) begin
            if (state == IDLE && start) begin
               op_q  <= op;
               opnd  <= src2;
               lo    <= src1;
               hi    <= '0;
               count <= '0;
            end else if (state == CALC) begin
               hi    <= hi_nxt;
               lo    <= lo_nxt;
               count <= count + 1'b1;
               // results land on the edge that enters DONE
               if (count == LAST) begin
                  des1  <= lo_nxt;
                  des2  <= hi_nxt;
                  desOv <= ov_nxt;
               end
            end
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
